// File: rtl/ip_checksum_partial_pkg.sv
// Shared state encoding and beat-0 header layout for the IPv4 partial-checksum stage.
package ip_checksum_partial_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_WAIT1,
        S_FLUSH1,
        S_BODY
    } state_e;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    localparam int unsigned ETHERTYPE_MSB = 159;
    localparam int unsigned W0_MSB        = 143;
    localparam int unsigned W9_MSB        = 255;
    localparam int unsigned HDR_WORDS     = 9;
    // Only the low beat-0 bits (ethertype plus header words 0..8) feed the sum logic.
    localparam int unsigned HDR_BITS      = ETHERTYPE_MSB + 1;

    function automatic logic [31:0] sum3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        return {16'h0000, a} + {16'h0000, b} + {16'h0000, c};
    endfunction

endpackage

// File: rtl/ip_hdr_word_sum.sv
// Combinational beat-0 decode: IPv4 check plus the three 3-word partial sums.
module ip_hdr_word_sum
    import ip_checksum_partial_pkg::*;
(
    input  logic [HDR_BITS-1:0] hdr_i,
    output logic [31:0]         sum01_o,
    output logic [31:0]         sum02_o,
    output logic [31:0]         sum03_o,
    output logic                is_ipv4_o
);

    logic [15:0] word [HDR_WORDS];
    logic [15:0] ethertype;
    logic        ipv4;

    for (genvar k = 0; k < HDR_WORDS; k++) begin : g_word
        assign word[k] = hdr_i[W0_MSB - 16*k -: 16];
    end

    assign ethertype = hdr_i[ETHERTYPE_MSB -: 16];

    always_comb begin
        ipv4    = (ethertype == ETHERTYPE_IPV4) && (word[0][15:8] == IPV4_VER_IHL);
        sum01_o = '0;
        sum02_o = '0;
        sum03_o = '0;
        if (ipv4) begin
            sum01_o = sum3(word[0], word[1], word[2]);
            sum02_o = sum3(word[3], word[4], word[5]);
            sum03_o = sum3(word[6], word[7], word[8]);
        end
        is_ipv4_o = ipv4;
    end

endmodule

// File: rtl/ip_checksum_partial.sv
// Two-register AXI4-Stream pass-through that presents IPv4 header partial sums aligned
// with each packet's first egress beat.
module ip_checksum_partial
    import ip_checksum_partial_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                               AXI_ACLK,
    input  logic                               AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    S_AXIS_TUSER,
    input  logic                               S_AXIS_TVALID,
    input  logic                               S_AXIS_TLAST,
    output logic                               S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    M_AXIS_TUSER,
    output logic                               M_AXIS_TVALID,
    output logic                               M_AXIS_TLAST,
    input  logic                               M_AXIS_TREADY,

    output logic [31:0]                        checksum01,
    output logic [31:0]                        checksum02,
    output logic [31:0]                        checksum03,
    output logic [31:0]                        checksum04,
    output logic                               is_ipv4
);

    state_e state_q, state_d;

    logic                              hold_valid_q, hold_valid_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  hold_strb_q, hold_strb_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   hold_user_q, hold_user_d;
    logic                              hold_last_q, hold_last_d;

    logic                              out_valid_q, out_valid_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  out_strb_q, out_strb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   out_user_q, out_user_d;
    logic                              out_last_q, out_last_d;

    logic [31:0] stg01_q, stg01_d;
    logic [31:0] stg02_q, stg02_d;
    logic [31:0] stg03_q, stg03_d;
    logic        stg_ipv4_q, stg_ipv4_d;

    logic [31:0] cks01_q, cks01_d;
    logic [31:0] cks02_q, cks02_d;
    logic [31:0] cks03_q, cks03_d;
    logic [31:0] cks04_q, cks04_d;
    logic        is_ipv4_q, is_ipv4_d;

    logic [31:0] hdr_sum01, hdr_sum02, hdr_sum03;
    logic        hdr_ipv4;

    logic out_free;
    logic hold_move;
    logic s_ready;
    logic accept;
    logic start_pkt;

    ip_hdr_word_sum u_hdr_sum (
        .hdr_i     (S_AXIS_TDATA[HDR_BITS-1:0]),
        .sum01_o   (hdr_sum01),
        .sum02_o   (hdr_sum02),
        .sum03_o   (hdr_sum03),
        .is_ipv4_o (hdr_ipv4)
    );

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_strb_d  = hold_strb_q;
        hold_user_d  = hold_user_q;
        hold_last_d  = hold_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;
        out_user_d   = out_user_q;
        out_last_d   = out_last_q;
        stg01_d      = stg01_q;
        stg02_d      = stg02_q;
        stg03_d      = stg03_q;
        stg_ipv4_d   = stg_ipv4_q;
        cks01_d      = cks01_q;
        cks02_d      = cks02_q;
        cks03_d      = cks03_q;
        cks04_d      = cks04_q;
        is_ipv4_d    = is_ipv4_q;
        start_pkt    = 1'b0;

        out_free = !out_valid_q || M_AXIS_TREADY;

        // In S_WAIT1 beat 0 may only leave HOLD together with the arrival of beat 1.
        unique case (state_q)
            S_HDR:    hold_move = 1'b0;
            S_WAIT1:  hold_move = out_free && S_AXIS_TVALID;
            S_FLUSH1: hold_move = out_free;
            S_BODY:   hold_move = hold_valid_q && out_free;
            default:  hold_move = 1'b0;
        endcase

        s_ready = !hold_valid_q || ((state_q != S_FLUSH1) && hold_move);
        accept  = S_AXIS_TVALID && s_ready;

        if (hold_move) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_strb_d  = hold_strb_q;
            out_user_d  = hold_user_q;
            out_last_d  = hold_last_q;
        end else if (M_AXIS_TREADY) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = S_AXIS_TDATA;
            hold_strb_d  = S_AXIS_TSTRB;
            hold_user_d  = S_AXIS_TUSER;
            hold_last_d  = S_AXIS_TLAST;
        end else if (hold_move) begin
            hold_valid_d = 1'b0;
        end

        unique case (state_q)
            S_HDR: begin
                start_pkt = accept;
            end
            S_WAIT1: begin
                if (hold_move) begin
                    cks01_d   = stg01_q;
                    cks02_d   = stg02_q;
                    cks03_d   = stg03_q;
                    cks04_d   = stg_ipv4_q ? {16'h0000, S_AXIS_TDATA[W9_MSB -: 16]} : 32'h0;
                    is_ipv4_d = stg_ipv4_q;
                    state_d   = S_BODY;
                end
            end
            S_FLUSH1: begin
                if (hold_move) begin
                    cks01_d   = stg01_q;
                    cks02_d   = stg02_q;
                    cks03_d   = stg03_q;
                    cks04_d   = 32'h0;
                    is_ipv4_d = stg_ipv4_q;
                    state_d   = S_HDR;
                end
            end
            S_BODY: begin
                // A beat accepted while the last beat leaves HOLD is the next packet's beat 0.
                if (hold_move && hold_last_q) begin
                    state_d   = S_HDR;
                    start_pkt = accept;
                end
            end
            default: ;
        endcase

        if (start_pkt) begin
            stg01_d    = hdr_sum01;
            stg02_d    = hdr_sum02;
            stg03_d    = hdr_sum03;
            stg_ipv4_d = hdr_ipv4;
            state_d    = S_AXIS_TLAST ? S_FLUSH1 : S_WAIT1;
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state_q      <= S_HDR;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_strb_q  <= '0;
            hold_user_q  <= '0;
            hold_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            stg01_q      <= '0;
            stg02_q      <= '0;
            stg03_q      <= '0;
            stg_ipv4_q   <= 1'b0;
            cks01_q      <= '0;
            cks02_q      <= '0;
            cks03_q      <= '0;
            cks04_q      <= '0;
            is_ipv4_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_strb_q  <= hold_strb_d;
            hold_user_q  <= hold_user_d;
            hold_last_q  <= hold_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            out_user_q   <= out_user_d;
            out_last_q   <= out_last_d;
            stg01_q      <= stg01_d;
            stg02_q      <= stg02_d;
            stg03_q      <= stg03_d;
            stg_ipv4_q   <= stg_ipv4_d;
            cks01_q      <= cks01_d;
            cks02_q      <= cks02_d;
            cks03_q      <= cks03_d;
            cks04_q      <= cks04_d;
            is_ipv4_q    <= is_ipv4_d;
        end
    end

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TSTRB  = out_strb_q;
    assign M_AXIS_TUSER  = out_user_q;
    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign checksum01    = cks01_q;
    assign checksum02    = cks02_q;
    assign checksum03    = cks03_q;
    assign checksum04    = cks04_q;
    assign is_ipv4       = is_ipv4_q;

endmodule

// File: tb/tb_ip_checksum_partial.sv
// Directed bench for ip_checksum_partial: scoreboarded egress, hand-computed header sums.
module tb_ip_checksum_partial;

    localparam logic [159:0] HDR_A = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
    localparam logic [159:0] HDR_B = 160'h4500_0054_1234_0000_4001_0000_0a00_0001_0a00_0002;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
        int unsigned  acc;
    } exp_beat_t;

    typedef struct {
        logic [31:0] c1;
        logic [31:0] c2;
        logic [31:0] c3;
        logic [31:0] c4;
        logic        v;
    } exp_sums_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [31:0]  cs1, cs2, cs3, cs4;
    logic         ipv4;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned ready_mode = 1;   // 0 low, 1 high, 2 random
    bit          lat_en = 1'b0;

    exp_beat_t exp_q[$];
    exp_sums_t sums_q[$];
    exp_sums_t cur;
    logic         in_pkt = 1'b0;
    logic         stalled = 1'b0;
    logic [255:0] prev_d;
    logic         prev_l;
    int unsigned  first_seen = 0;

    ip_checksum_partial dut (
        .AXI_ACLK      (clk),
        .AXI_RESET     (rst),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .checksum01    (cs1),
        .checksum02    (cs2),
        .checksum03    (cs3),
        .checksum04    (cs4),
        .is_ipv4       (ipv4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_beat(input logic [159:0] hdr, input logic [15:0] eth,
                                             input int b, input logic [31:0] tag);
        if (b == 0) return {96'h0011_2233_4455_6677_8899_aabb, eth, hdr[159:16]};
        return {hdr[15:0], {7{tag}}, 16'(b)};
    endfunction

    task automatic drive(input logic [159:0] hdr, input logic [15:0] eth, input int b,
                         input int nb, input logic [31:0] tag);
        s_tdata  = mk_beat(hdr, eth, b, tag);
        s_tstrb  = (b == nb - 1) ? 32'hffff_0000 : 32'hffff_ffff;
        s_tuser  = {tag, 64'h0, 32'(b)};
        s_tlast  = (b == nb - 1);
        s_tvalid = 1'b1;
    endtask

    // Entered and left at posedge+1; waits for acceptance with a bounded budget.
    task automatic send_idx(input logic [159:0] hdr, input logic [15:0] eth, input int b,
                            input int nb, input logic [31:0] tag);
        exp_beat_t e;
        bit done = 1'b0;
        drive(hdr, eth, b, nb, tag);
        for (int t = 0; t < 80 && !done; t++) begin
            @(negedge clk);
            if (s_tready) begin
                e.d = s_tdata; e.s = s_tstrb; e.u = s_tuser; e.l = s_tlast; e.acc = cyc;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", {255'b0, done}, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic push_sums(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3,
                             input logic [31:0] c4, input logic v);
        exp_sums_t s;
        s.c1 = c1; s.c2 = c2; s.c3 = c3; s.c4 = c4; s.v = v;
        sums_q.push_back(s);
    endtask

    task automatic send_pkt(input logic [159:0] hdr, input logic [15:0] eth, input int nb,
                            input logic [31:0] tag, input logic [31:0] c1, input logic [31:0] c2,
                            input logic [31:0] c3, input logic [31:0] c4, input logic v);
        push_sums(c1, c2, c3, c4, v);
        for (int b = 0; b < nb; b++) send_idx(hdr, eth, b, nb, tag);
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic score_beat();
        exp_beat_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_beat", m_tvalid, 0);
            return;
        end
        e = exp_q.pop_front();
        check("data", m_tdata, e.d);
        check("strb", m_tstrb, e.s);
        check("user", m_tuser, e.u);
        check("last", m_tlast, e.l);
        if (!in_pkt && sums_q.size() != 0) cur = sums_q.pop_front();
        if (lat_en) check("latency", first_seen - e.acc, 2);
        check("checksum01", cs1, cur.c1);
        check("checksum02", cs2, cur.c2);
        check("checksum03", cs3, cur.c3);
        check("checksum04", cs4, cur.c4);
        check("is_ipv4", ipv4, cur.v);
        in_pkt = !m_tlast;
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                in_pkt  = 1'b0;
            end else if (m_tvalid) begin
                if (stalled) begin
                    check("stall_data", m_tdata, prev_d);
                    check("stall_last", m_tlast, prev_l);
                end else begin
                    first_seen = cyc;
                end
                if (m_tready) begin
                    stalled = 1'b0;
                    score_beat();
                end else begin
                    stalled = 1'b1;
                    prev_d  = m_tdata;
                    prev_l  = m_tlast;
                end
            end else if (stalled) begin
                check("tvalid_withdrawn", m_tvalid, 1);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int rdy_cnt;
        rst = 1'b1;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_cs1", cs1, 0);
        check("rst_cs2", cs2, 0);
        check("rst_cs3", cs3, 0);
        check("rst_cs4", cs4, 0);
        check("rst_ipv4", ipv4, 0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", s_tready, 1);
        @(posedge clk); #1;

        // IPv4, ARP and single-beat packets back to back, no backpressure.
        lat_en = 1'b1;
        send_pkt(HDR_A, 16'h0800, 3, 32'ha1, 32'h4573, 32'h13872, 32'h18151, 32'h00c7, 1'b1);
        send_pkt(HDR_A, 16'h0806, 3, 32'ha2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        send_pkt(HDR_A, 16'h0800, 1, 32'ha3, 32'h4573, 32'h13872, 32'h18151, 32'h0, 1'b1);
        wait_drain("drain_directed");
        check("held_cs1", cs1, 32'h4573);
        check("held_cs4", cs4, 32'h0);
        check("held_ipv4", ipv4, 1);
        lat_en = 1'b0;

        // Alternating 2-beat packets under random egress backpressure.
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            send_pkt(HDR_A, 16'h0800, 2, 32'hb0 + 32'(i), 32'h4573, 32'h13872, 32'h18151,
                     32'h00c7, 1'b1);
            send_pkt(HDR_B, 16'h0800, 2, 32'hc0 + 32'(i), 32'h5788, 32'h4001, 32'h1401,
                     32'h0002, 1'b1);
        end
        ready_mode = 1;
        wait_drain("drain_random");

        // Reset while beat 0 sits stalled in OUT and beat 1 in HOLD.
        ready_mode = 0;
        @(posedge clk); #1;
        push_sums(32'h4573, 32'h13872, 32'h18151, 32'h00c7, 1'b1);
        send_idx(HDR_A, 16'h0800, 0, 3, 32'hd1);
        send_idx(HDR_A, 16'h0800, 1, 3, 32'hd1);
        check("pre_rst_tvalid", m_tvalid, 1);
        check("pre_rst_cs1", cs1, 32'h4573);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_cs1", cs1, 0);
        check("mid_rst_cs2", cs2, 0);
        check("mid_rst_cs4", cs4, 0);
        check("mid_rst_ipv4", ipv4, 0);
        exp_q.delete();
        sums_q.delete();
        in_pkt = 1'b0;
        ready_mode = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_pkt(HDR_B, 16'h0800, 2, 32'hd2, 32'h5788, 32'h4001, 32'h1401, 32'h0002, 1'b1);
        wait_drain("drain_after_rst");

        // Egress held off for 10 cycles: ingress must stall once HOLD and OUT are full.
        ready_mode = 0;
        @(posedge clk); #1;
        push_sums(32'h5788, 32'h4001, 32'h1401, 32'h0002, 1'b1);
        send_idx(HDR_B, 16'h0800, 0, 3, 32'he1);
        send_idx(HDR_B, 16'h0800, 1, 3, 32'he1);
        drive(HDR_B, 16'h0800, 2, 3, 32'he1);
        rdy_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            rdy_cnt += int'(s_tready);
        end
        @(posedge clk); #1;
        check("stall_tready", rdy_cnt, 0);
        check("stall_tvalid", m_tvalid, 1);
        ready_mode = 1;
        send_idx(HDR_B, 16'h0800, 2, 3, 32'he1);
        wait_drain("drain_backpressure");
        check("sums_consumed", sums_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
